// File: rtl/exe_issue_queue_pkg.sv
// Shared types and defaults for the exe_unit_w1 issue path.
package exe_pkg;

  localparam int EXE_M = 4;
  localparam int EXE_N = 2;

  typedef struct packed {
    logic [EXE_N-1:0] oper;
    logic [EXE_M-1:0] argA;
    logic [EXE_M-1:0] argB;
  } exe_cmd_t;

  // Opcodes select exe_unit_w1 sub-modules mod1..mod4.
  typedef enum logic [EXE_N-1:0] {
    OPER_0 = 2'b00,
    OPER_1 = 2'b01,
    OPER_2 = 2'b10,
    OPER_3 = 2'b11
  } exe_oper_e;

endpackage

// File: rtl/exe_issue_queue_cmd_fifo.sv
// Circular command store for exe_issue_queue: storage, pointers, occupancy, full/empty.
module exe_cmd_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rsn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic [1:0]    state;
  logic [1:0]    state_next;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // State is a pure function of the next occupancy, so it can never disagree with count.
  always_comb begin
    state_next = S_ACTIVE;
    if (count_next == '0)
      state_next = S_EMPTY;
    else if (count_next == CW'(DEPTH))
      state_next = S_FULL;
  end

  always_ff @(posedge clk) begin
    if (!rsn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= S_EMPTY;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rsn && !flush && push)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (state == S_FULL);
  assign empty = (state == S_EMPTY);

endmodule

// File: rtl/exe_issue_queue.sv
// Issue queue feeding exe_unit_w1 operand ports; tracks its one-cycle result latency.
// Optional same-edge bypass into an empty queue: define EXE_ISSUE_QUEUE_BYPASS_EN.
module exe_issue_queue
  import exe_pkg::*;
#(
  parameter int m = EXE_M,
  parameter int n = EXE_N,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rsn,
  input  logic                     i_valid,
  input  logic [n-1:0]             i_oper,
  input  logic [m-1:0]             i_argA,
  input  logic [m-1:0]             i_argB,
  output logic                     o_ready,
  input  logic                     i_stall,
  input  logic                     i_flush,
  output logic [n-1:0]             o_oper,
  output logic [m-1:0]             o_argA,
  output logic [m-1:0]             o_argB,
  output logic                     o_issue_valid,
  output logic                     o_res_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int W = n + 2 * m;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         bypass;
  logic [W-1:0] head;

  always_comb begin
    bypass = 1'b0;
`ifdef EXE_ISSUE_QUEUE_BYPASS_EN
    bypass = empty && i_valid && !i_stall && !i_flush;
`endif
  end

  assign push    = i_valid && !full && !bypass;
  assign pop     = !empty && !i_stall;
  assign o_ready = !full;

  exe_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rsn   (i_rsn),
    .push  (push),
    .pop   (pop),
    .flush (i_flush),
    .wdata ({i_oper, i_argA, i_argB}),
    .rdata (head),
    .count (o_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      o_oper        <= '0;
      o_argA        <= '0;
      o_argB        <= '0;
      o_issue_valid <= 1'b0;
      o_res_valid   <= 1'b0;
    end else if (i_flush) begin
      o_issue_valid <= 1'b0;
      o_res_valid   <= 1'b0;
    end else begin
      o_res_valid <= o_issue_valid;
      if (pop) begin
        {o_oper, o_argA, o_argB} <= head;
        o_issue_valid            <= 1'b1;
      end else if (bypass) begin
        {o_oper, o_argA, o_argB} <= {i_oper, i_argA, i_argB};
        o_issue_valid            <= 1'b1;
      end else begin
        o_issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/exe_issue_queue.md
Name: exe_issue_queue

Overview:
- Upstream neighbour of exe_unit_w1. Buffers operation commands (oper, argA, argB) from the producer in a small circular FIFO.
- Issues at most one command per cycle into the execution unit's operand ports.
- Tracks the execution unit's one-cycle registered latency and flags the cycle in which the unit's o_result/o_status are valid for the issued command.

Parameters:
- m, 4, operand/result width; must match exe_unit_w1 m.
- n, 2, opcode width; must match exe_unit_w1 n.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rsn  input  1  reset, synchronous, active-low.
- i_valid  input  1  producer command valid.
- i_oper  input  n  command opcode.
- i_argA  input  m  command operand A.
- i_argB  input  m  command operand B.
- o_ready  output  1  queue can accept; equals (count < DEPTH); registered-state only, no combinational path from i_valid/i_stall.
- i_stall  input  1  downstream hold; no issue while high.
- i_flush  input  1  discard queued and in-flight commands.
- o_oper  output  n  to exe_unit_w1 i_oper (registered).
- o_argA  output  m  to exe_unit_w1 i_argA (registered).
- o_argB  output  m  to exe_unit_w1 i_argB (registered).
- o_issue_valid  output  1  o_oper/o_argA/o_argB carry a live command this cycle.
- o_res_valid  output  1  exe_unit_w1 o_result/o_status belong to a live command this cycle.
- o_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (i_rsn==0 at edge): count=0, rd/wr pointers=0, o_oper/o_argA/o_argB=0, o_issue_valid=0, o_res_valid=0. Applies mid-operation; all queued and in-flight commands are lost.
- Push: accepted at an edge iff i_valid && o_ready. Entry is written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Pop/issue: at an edge, if count>0 && !i_stall, the head entry is loaded into the o_oper/o_argA/o_argB registers, o_issue_valid is set to 1, and rd_ptr advances with wrap. Otherwise o_issue_valid is set to 0 and the operand registers hold their values (no toggling).
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged.
- Full: o_ready=0; a concurrent pop does not re-open o_ready in the same cycle.
- Empty, without bypass: a command pushed at edge k issues at edge k+1 at the earliest.
- Result tracking: o_res_valid at edge k+1 = o_issue_valid value before edge k+1. exe_unit_w1 registers its outputs on the same edge, so o_res_valid aligns with its o_result/o_status.
- Flush (lower priority than reset, higher than push/pop): clears count/pointers, o_issue_valid=0, o_res_valid=0 at that edge. A push in the same cycle is dropped. Operand registers hold their values.
- Stall: freezes pops only; pushes continue until full. o_res_valid still retires the command already issued.
- FSM (on count): EMPTY(count==0) -> ACTIVE on push; ACTIVE -> FULL when count reaches DEPTH; ACTIVE -> EMPTY on last pop with no push; FULL -> ACTIVE on pop; any state -> EMPTY on flush/reset.

Optional Feature:
- Macro EXE_ISSUE_QUEUE_BYPASS_EN.
- Defined: when count==0 && i_valid && !i_stall && !i_flush, the command goes straight into the operand registers at the same edge. o_issue_valid=1 after that edge; count stays 0. This gives a one-cycle push-to-issue latency.
- Undefined: all commands pass through FIFO storage; push-to-issue is at least two edges.
- o_ready is identical in both builds.

Decomposition:
- Package exe_pkg holds:
  - typedef exe_cmd_t (packed struct: oper[n], argA[m], argB[m]);
  - opcode enum OPER_0=2'b00..OPER_3=2'b11 selecting exe_unit_w1 sub-modules mod1..mod4;
  - localparams for default m=4, n=2.
- Sub-module exe_cmd_fifo (storage, pointers, count, full/empty) sits under exe_issue_queue. Issue/result-tracking logic stays in the top.

Test Plan:
- Reset: drive i_rsn=0 for 2 edges with i_valid=1 -> o_count=0, o_issue_valid=0, o_res_valid=0, o_oper/o_argA/o_argB=0, o_ready=1.
- Single command: push (oper=2'b01, A=4'h3, B=4'h5) at edge 1 -> o_issue_valid=1 after edge 2 with o_oper=2'b01, o_argA=3, o_argB=5; o_res_valid=1 after edge 3, then 0.
- Fill/wrap: with i_stall=1, push 5 commands -> 4 accepted, o_ready=0, o_count=4. Release i_stall -> issued in push order over 4 consecutive cycles. Push 2 more -> correct order across the pointer wrap.
- Simultaneous push/pop at o_count=2: each cycle -> o_count stays 2 and issue order is preserved.
- Flush: o_count=3 with a command in flight, i_flush=1 plus i_valid=1 -> after the edge o_count=0, o_issue_valid=0, o_res_valid=0; the pushed command is never issued.
- Bypass (macro defined): push at edge k into an empty queue -> o_issue_valid=1 after edge k, o_count stays 0. Macro undefined -> issue after edge k+1.
